// File: rtl/exc_detect_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : exc_detect_pipe
//  Purpose  : Detects per-instruction exceptions in IF, ID and EX and carries
//             a prioritised exception record through the IF/ID, ID/EX and
//             EX/MEM registers to the CP0 unit in MEM. Owns the valid/allowin
//             handshake for these records, delay-slot (BD) tracking and
//             pipeline flush.
//  Ports    :
//    clk, resetn          clock, synchronous active-low reset
//    flush                CP0 clear_pipeline, kills ID/EX/MEM at next edge
//    if_valid, if_pc      fetched instruction presented by IF
//    id_inst, id_is_branch, id_inst_reserved, id_ready_go   ID stage inputs
//    ex_ready_go, ex_overflow, ex_mem_addr, ex_ld_*/ex_st_* EX stage inputs
//    mem_allowin          MEM stage can accept a new record
//    id_allowin           back-pressure to IF
//    ex_kill_store        suppress the data SRAM write of the EX instruction
//    mem_*                exception record at the EX/MEM boundary
//  Revision : 1.0  initial release
// ============================================================================
module exc_detect_pipe #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        flush,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] id_inst,
    input  logic        id_is_branch,
    input  logic        id_inst_reserved,
    input  logic        id_ready_go,
    input  logic        ex_ready_go,
    input  logic        ex_overflow,
    input  logic [31:0] ex_mem_addr,
    input  logic        ex_ld_w,
    input  logic        ex_ld_h,
    input  logic        ex_st_w,
    input  logic        ex_st_h,
    input  logic        mem_allowin,
    output logic        id_allowin,
    output logic        ex_kill_store,
    output logic        mem_valid,
    output logic [31:0] mem_pc,
    output logic        mem_set_cp0,
    output logic [4:0]  mem_addr_cp0,
    output logic [31:0] mem_badaddr,
    output logic        mem_bd,
    output logic        mem_eret,
    output logic        mem_exc_fetch,
    output logic        mem_exc_reserved,
    output logic        mem_exc_instruction,
    output logic        mem_exc_data,
    output logic        mem_adel,
    output logic        mem_ades,
    output logic        mem_sys,
    output logic        mem_bp,
    output logic        mem_ri,
    output logic        mem_ov
);

    localparam logic [5:0]  c_OP_SPECIAL    = 6'h00;
    localparam logic [5:0]  c_OP_COP0       = 6'h10;
    localparam logic [5:0]  c_FUNCT_SYSCALL = 6'h0C;
    localparam logic [5:0]  c_FUNCT_BREAK   = 6'h0D;
    localparam logic [4:0]  c_RS_MTC0       = 5'h04;
    localparam logic [31:0] c_INST_ERET     = 32'h42000018;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic        r_id_adel;
    logic [31:0] r_id_badaddr;

    logic        r_prev_branch;

    logic        r_ex_valid;
    logic [31:0] r_ex_pc;
    logic        r_ex_set_cp0;
    logic [4:0]  r_ex_addr_cp0;
    logic [31:0] r_ex_badaddr;
    logic        r_ex_bd;
    logic        r_ex_eret;
    logic        r_ex_exc_fetch;
    logic        r_ex_exc_reserved;
    logic        r_ex_exc_instruction;
    logic        r_ex_adel;
    logic        r_ex_sys;
    logic        r_ex_bp;
    logic        r_ex_ri;

    logic        r_mem_valid;
    logic [31:0] r_mem_pc;
    logic        r_mem_set_cp0;
    logic [4:0]  r_mem_addr_cp0;
    logic [31:0] r_mem_badaddr;
    logic        r_mem_bd;
    logic        r_mem_eret;
    logic        r_mem_exc_fetch;
    logic        r_mem_exc_reserved;
    logic        r_mem_exc_instruction;
    logic        r_mem_exc_data;
    logic        r_mem_adel;
    logic        r_mem_ades;
    logic        r_mem_sys;
    logic        r_mem_bp;
    logic        r_mem_ri;
    logic        r_mem_ov;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_ex_allowin;
    logic w_id_allowin;
    logic w_if_to_id;
    logic w_id_to_ex;
    logic w_ex_to_mem;

    assign w_ex_allowin = !r_ex_valid | (ex_ready_go & mem_allowin);
    assign w_id_allowin = !r_id_valid | (id_ready_go & w_ex_allowin);
    assign w_if_to_id   = if_valid & w_id_allowin;
    assign w_id_to_ex   = r_id_valid & id_ready_go & w_ex_allowin;
    assign w_ex_to_mem  = r_ex_valid & ex_ready_go & mem_allowin;

    // ------------------------------------------------------------------
    // ID detection (suppressed behind a fetch exception)
    // ------------------------------------------------------------------
    logic w_id_is_special;
    logic w_id_ri;
    logic w_id_sys;
    logic w_id_bp;
    logic w_id_any_exc;
    logic w_id_mtc0;
    logic w_id_eret;

    assign w_id_is_special = (id_inst[31:26] == c_OP_SPECIAL);
    assign w_id_ri   = !r_id_adel & id_inst_reserved;
    // RI outranks Sys/Bp so a reserved encoding never reports a syscall.
    assign w_id_sys  = !r_id_adel & !id_inst_reserved & w_id_is_special
                       & (id_inst[5:0] == c_FUNCT_SYSCALL);
    assign w_id_bp   = !r_id_adel & !id_inst_reserved & w_id_is_special
                       & (id_inst[5:0] == c_FUNCT_BREAK);
    assign w_id_any_exc = r_id_adel | w_id_ri | w_id_sys | w_id_bp;
    assign w_id_mtc0 = (id_inst[31:26] == c_OP_COP0) & (id_inst[25:21] == c_RS_MTC0);
    assign w_id_eret = (id_inst == c_INST_ERET);

    // ------------------------------------------------------------------
    // EX detection (suppressed behind any earlier exception)
    // ------------------------------------------------------------------
    logic w_ex_prior_exc;
    logic w_ex_ld_err;
    logic w_ex_st_err;
    logic w_ex_ov;
    logic w_ex_dadel;
    logic w_ex_dades;
    logic w_ex_any_exc;

    assign w_ex_prior_exc = r_ex_exc_fetch | r_ex_exc_reserved | r_ex_exc_instruction;
    assign w_ex_ld_err = (ex_ld_w & (ex_mem_addr[1:0] != 2'b00)) | (ex_ld_h & ex_mem_addr[0]);
    assign w_ex_st_err = (ex_st_w & (ex_mem_addr[1:0] != 2'b00)) | (ex_st_h & ex_mem_addr[0]);
    // Overflow outranks an address error; AdEL outranks AdES to keep the
    // cause flags one-hot even for malformed access-type combinations.
    assign w_ex_ov    = !w_ex_prior_exc & ex_overflow;
    assign w_ex_dadel = !w_ex_prior_exc & !ex_overflow & w_ex_ld_err;
    assign w_ex_dades = !w_ex_prior_exc & !ex_overflow & !w_ex_ld_err & w_ex_st_err;
    assign w_ex_any_exc = w_ex_prior_exc | w_ex_ov | w_ex_dadel | w_ex_dades;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_id_valid   <= 1'b0;
            r_id_pc      <= RESET_PC;
            r_id_adel    <= 1'b0;
            r_id_badaddr <= 32'h0;
        end else begin
            if (flush) begin
                r_id_valid <= 1'b0;
            end else if (w_id_allowin) begin
                r_id_valid <= if_valid;
            end
            if (w_if_to_id) begin
                r_id_pc      <= if_pc;
                r_id_adel    <= (if_pc[1:0] != 2'b00);
                r_id_badaddr <= (if_pc[1:0] != 2'b00) ? if_pc : 32'h0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ID/EX register and delay-slot tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ex_valid           <= 1'b0;
            r_prev_branch        <= 1'b0;
            r_ex_pc              <= RESET_PC;
            r_ex_set_cp0         <= 1'b0;
            r_ex_addr_cp0        <= 5'd0;
            r_ex_badaddr         <= 32'h0;
            r_ex_bd              <= 1'b0;
            r_ex_eret            <= 1'b0;
            r_ex_exc_fetch       <= 1'b0;
            r_ex_exc_reserved    <= 1'b0;
            r_ex_exc_instruction <= 1'b0;
            r_ex_adel            <= 1'b0;
            r_ex_sys             <= 1'b0;
            r_ex_bp              <= 1'b0;
            r_ex_ri              <= 1'b0;
        end else begin
            if (flush) begin
                r_ex_valid    <= 1'b0;
                r_prev_branch <= 1'b0;
            end else begin
                if (w_ex_allowin) begin
                    r_ex_valid <= r_id_valid & id_ready_go;
                end
                if (w_id_to_ex) begin
                    r_prev_branch <= id_is_branch;
                end
            end
            if (w_id_to_ex) begin
                r_ex_pc              <= r_id_pc;
                r_ex_set_cp0         <= w_id_mtc0 & !w_id_any_exc;
                r_ex_addr_cp0        <= id_inst[15:11];
                r_ex_badaddr         <= r_id_badaddr;
                // The instruction entering EX is in a delay slot when the one
                // ahead of it in program order was a branch.
                r_ex_bd              <= r_prev_branch;
                r_ex_eret            <= w_id_eret & !w_id_any_exc;
                r_ex_exc_fetch       <= r_id_adel;
                r_ex_exc_reserved    <= w_id_ri;
                r_ex_exc_instruction <= w_id_sys | w_id_bp;
                r_ex_adel            <= r_id_adel;
                r_ex_sys             <= w_id_sys;
                r_ex_bp              <= w_id_bp;
                r_ex_ri              <= w_id_ri;
            end
        end
    end

    // ------------------------------------------------------------------
    // EX/MEM register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_valid           <= 1'b0;
            r_mem_pc              <= RESET_PC;
            r_mem_set_cp0         <= 1'b0;
            r_mem_addr_cp0        <= 5'd0;
            r_mem_badaddr         <= 32'h0;
            r_mem_bd              <= 1'b0;
            r_mem_eret            <= 1'b0;
            r_mem_exc_fetch       <= 1'b0;
            r_mem_exc_reserved    <= 1'b0;
            r_mem_exc_instruction <= 1'b0;
            r_mem_exc_data        <= 1'b0;
            r_mem_adel            <= 1'b0;
            r_mem_ades            <= 1'b0;
            r_mem_sys             <= 1'b0;
            r_mem_bp              <= 1'b0;
            r_mem_ri              <= 1'b0;
            r_mem_ov              <= 1'b0;
        end else begin
            if (flush) begin
                r_mem_valid <= 1'b0;
            end else if (mem_allowin) begin
                r_mem_valid <= r_ex_valid & ex_ready_go;
            end
            if (w_ex_to_mem) begin
                r_mem_pc              <= r_ex_pc;
                r_mem_set_cp0         <= r_ex_set_cp0 & !w_ex_any_exc;
                r_mem_addr_cp0        <= r_ex_addr_cp0;
                r_mem_badaddr         <= (w_ex_dadel | w_ex_dades) ? ex_mem_addr : r_ex_badaddr;
                r_mem_bd              <= r_ex_bd;
                r_mem_eret            <= r_ex_eret & !w_ex_any_exc;
                r_mem_exc_fetch       <= r_ex_exc_fetch;
                r_mem_exc_reserved    <= r_ex_exc_reserved;
                r_mem_exc_instruction <= r_ex_exc_instruction | w_ex_ov;
                r_mem_exc_data        <= w_ex_dadel | w_ex_dades;
                r_mem_adel            <= r_ex_adel | w_ex_dadel;
                r_mem_ades            <= w_ex_dades;
                r_mem_sys             <= r_ex_sys;
                r_mem_bp              <= r_ex_bp;
                r_mem_ri              <= r_ex_ri;
                r_mem_ov              <= w_ex_ov;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: every flag is qualified by the record's valid bit so stale
    // contents left behind by a flush or bubble never reach CP0.
    // ------------------------------------------------------------------
    logic w_mem_any_exc;
    assign w_mem_any_exc = r_mem_exc_fetch | r_mem_exc_reserved
                         | r_mem_exc_instruction | r_mem_exc_data;

    assign id_allowin          = w_id_allowin;
    assign ex_kill_store       = r_ex_valid & (w_ex_any_exc
                                 | (r_mem_valid & (w_mem_any_exc | r_mem_eret))
                                 | flush);
    assign mem_valid           = r_mem_valid;
    assign mem_pc              = r_mem_pc;
    assign mem_addr_cp0        = r_mem_addr_cp0;
    assign mem_badaddr         = r_mem_badaddr;
    assign mem_set_cp0         = r_mem_valid & r_mem_set_cp0;
    assign mem_bd              = r_mem_valid & r_mem_bd;
    assign mem_eret            = r_mem_valid & r_mem_eret;
    assign mem_exc_fetch       = r_mem_valid & r_mem_exc_fetch;
    assign mem_exc_reserved    = r_mem_valid & r_mem_exc_reserved;
    assign mem_exc_instruction = r_mem_valid & r_mem_exc_instruction;
    assign mem_exc_data        = r_mem_valid & r_mem_exc_data;
    assign mem_adel            = r_mem_valid & r_mem_adel;
    assign mem_ades            = r_mem_valid & r_mem_ades;
    assign mem_sys             = r_mem_valid & r_mem_sys;
    assign mem_bp              = r_mem_valid & r_mem_bp;
    assign mem_ri              = r_mem_valid & r_mem_ri;
    assign mem_ov              = r_mem_valid & r_mem_ov;

endmodule
`default_nettype wire

// File: tb/tb_exc_detect_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exc_detect_pipe
//  Purpose  : Directed self-checking bench for exc_detect_pipe. Instructions
//             are walked one at a time through IF -> ID -> EX -> MEM and the
//             record arriving in MEM is compared with hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exc_detect_pipe;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] id_inst;
    logic        id_is_branch;
    logic        id_inst_reserved;
    logic        id_ready_go;
    logic        ex_ready_go;
    logic        ex_overflow;
    logic [31:0] ex_mem_addr;
    logic        ex_ld_w, ex_ld_h, ex_st_w, ex_st_h;
    logic        mem_allowin;
    logic        id_allowin;
    logic        ex_kill_store;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_set_cp0;
    logic [4:0]  mem_addr_cp0;
    logic [31:0] mem_badaddr;
    logic        mem_bd, mem_eret;
    logic        mem_exc_fetch, mem_exc_reserved, mem_exc_instruction, mem_exc_data;
    logic        mem_adel, mem_ades, mem_sys, mem_bp, mem_ri, mem_ov;

    int total;
    int bad;

    // Flag vector order:
    //   adel ades sys bp ri ov | fetch reserved instruction data | set_cp0 bd eret
    logic [12:0] flags;
    assign flags = {mem_adel, mem_ades, mem_sys, mem_bp, mem_ri, mem_ov,
                    mem_exc_fetch, mem_exc_reserved, mem_exc_instruction, mem_exc_data,
                    mem_set_cp0, mem_bd, mem_eret};

    exc_detect_pipe #(.RESET_PC(32'hBFC00000)) dut (
        .clk                 (clk),
        .resetn              (resetn),
        .flush               (flush),
        .if_valid            (if_valid),
        .if_pc               (if_pc),
        .id_inst             (id_inst),
        .id_is_branch        (id_is_branch),
        .id_inst_reserved    (id_inst_reserved),
        .id_ready_go         (id_ready_go),
        .ex_ready_go         (ex_ready_go),
        .ex_overflow         (ex_overflow),
        .ex_mem_addr         (ex_mem_addr),
        .ex_ld_w             (ex_ld_w),
        .ex_ld_h             (ex_ld_h),
        .ex_st_w             (ex_st_w),
        .ex_st_h             (ex_st_h),
        .mem_allowin         (mem_allowin),
        .id_allowin          (id_allowin),
        .ex_kill_store       (ex_kill_store),
        .mem_valid           (mem_valid),
        .mem_pc              (mem_pc),
        .mem_set_cp0         (mem_set_cp0),
        .mem_addr_cp0        (mem_addr_cp0),
        .mem_badaddr         (mem_badaddr),
        .mem_bd              (mem_bd),
        .mem_eret            (mem_eret),
        .mem_exc_fetch       (mem_exc_fetch),
        .mem_exc_reserved    (mem_exc_reserved),
        .mem_exc_instruction (mem_exc_instruction),
        .mem_exc_data        (mem_exc_data),
        .mem_adel            (mem_adel),
        .mem_ades            (mem_ades),
        .mem_sys             (mem_sys),
        .mem_bp              (mem_bp),
        .mem_ri              (mem_ri),
        .mem_ov              (mem_ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walks one instruction through the pipe. Called at #1 after an edge;
    // returns at #1 after the edge that loads the record into MEM.
    // acc = {ld_w, ld_h, st_w, st_h}. kill returns ex_kill_store seen in EX.
    task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                         input logic rsv, input logic br, input logic ov,
                         input logic [3:0] acc, input logic [31:0] addr,
                         output logic kill);
        if_valid = 1'b1;
        if_pc    = pc;
        @(posedge clk); #1;
        if_valid         = 1'b0;
        id_inst          = inst;
        id_inst_reserved = rsv;
        id_is_branch     = br;
        @(posedge clk); #1;
        id_inst          = 32'h0;
        id_inst_reserved = 1'b0;
        id_is_branch     = 1'b0;
        ex_overflow      = ov;
        {ex_ld_w, ex_ld_h, ex_st_w, ex_st_h} = acc;
        ex_mem_addr      = addr;
        #1;
        kill = ex_kill_store;
        @(posedge clk); #1;
        ex_overflow = 1'b0;
        {ex_ld_w, ex_ld_h, ex_st_w, ex_st_h} = 4'b0000;
        ex_mem_addr = 32'h0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (mem_valid !== 1'b0 || flags !== 13'b0) begin
            bad++;
            $display("FAIL reset_flags: got valid=%b flags=%b, want 0/0", mem_valid, flags);
        end
        total++;
        if (mem_pc !== 32'hBFC00000 || mem_badaddr !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc: got pc=%h badaddr=%h, want bfc00000/0", mem_pc, mem_badaddr);
        end
        total++;
        if (id_allowin !== 1'b1 || ex_kill_store !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: got allowin=%b kill=%b, want 1/0", id_allowin, ex_kill_store);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fetch;
        logic k;
        // Misaligned fetch; RI on the same instruction must be masked.
        issue(32'hBFC00002, 32'h0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (mem_valid !== 1'b1 || flags !== 13'b100000_1000_000) begin
            bad++;
            $display("FAIL fetch_flags: got valid=%b flags=%b, want 1/1000001000000", mem_valid, flags);
        end
        total++;
        if (mem_badaddr !== 32'hBFC00002 || mem_pc !== 32'hBFC00002) begin
            bad++;
            $display("FAIL fetch_addr: got badaddr=%h pc=%h, want bfc00002", mem_badaddr, mem_pc);
        end
        // Record drains next edge: flags must be gated off.
        @(posedge clk); #1;
        total++;
        if (mem_valid !== 1'b0 || flags !== 13'b0) begin
            bad++;
            $display("FAIL drain_gate: got valid=%b flags=%b, want 0/0", mem_valid, flags);
        end
    endtask

    task automatic test_syscall;
        logic k;
        issue(32'hBFC00100, 32'h0000000C, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b001000_0010_000 || mem_pc !== 32'hBFC00100) begin
            bad++;
            $display("FAIL sys: got flags=%b pc=%h, want 0010000010000/bfc00100", flags, mem_pc);
        end
        total++;
        if (k !== 1'b1) begin
            bad++;
            $display("FAIL sys_kill: got %b, want 1", k);
        end
        issue(32'hBFC00100, 32'h0000000C, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b000010_0100_000) begin
            bad++;
            $display("FAIL ri_over_sys: got flags=%b, want 0000100100000", flags);
        end
        issue(32'hBFC00104, 32'h0000000D, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b000100_0010_000) begin
            bad++;
            $display("FAIL bp: got flags=%b, want 0001000010000", flags);
        end
    endtask

    task automatic test_bd;
        logic k;
        issue(32'hBFC00200, 32'h10000004, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b0 || mem_valid !== 1'b1) begin
            bad++;
            $display("FAIL bd_branch: got valid=%b flags=%b, want 1/0", mem_valid, flags);
        end
        issue(32'hBFC00204, 32'h0000000C, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b001000_0010_010) begin
            bad++;
            $display("FAIL bd_slot: got flags=%b, want 0010000010010", flags);
        end
        issue(32'hBFC00208, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b0 || mem_pc !== 32'hBFC00208) begin
            bad++;
            $display("FAIL bd_after: got flags=%b pc=%h, want 0/bfc00208", flags, mem_pc);
        end
    endtask

    task automatic test_data;
        logic k;
        issue(32'hBFC00300, 32'h8C000000, 1'b0, 1'b0, 1'b0, 4'b1000, 32'h80001001, k);
        total++;
        if (flags !== 13'b100000_0001_000 || mem_badaddr !== 32'h80001001) begin
            bad++;
            $display("FAIL adel_data: got flags=%b badaddr=%h, want 1000000001000/80001001", flags, mem_badaddr);
        end
        issue(32'hBFC00304, 32'hA4000000, 1'b0, 1'b0, 1'b0, 4'b0001, 32'h80001001, k);
        total++;
        if (flags !== 13'b010000_0001_000 || mem_badaddr !== 32'h80001001) begin
            bad++;
            $display("FAIL ades: got flags=%b badaddr=%h, want 0100000001000/80001001", flags, mem_badaddr);
        end
        total++;
        if (k !== 1'b1) begin
            bad++;
            $display("FAIL ades_kill: got %b, want 1", k);
        end
        // Aligned word store: no exception, store not killed.
        issue(32'hBFC00308, 32'hAC000000, 1'b0, 1'b0, 1'b0, 4'b0010, 32'h80001000, k);
        total++;
        if (flags !== 13'b0 || k !== 1'b0) begin
            bad++;
            $display("FAIL store_ok: got flags=%b kill=%b, want 0/0", flags, k);
        end
        // Overflow together with misaligned load: OV wins.
        issue(32'hBFC0030C, 32'h00000020, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h80001002, k);
        total++;
        if (flags !== 13'b000001_0010_000) begin
            bad++;
            $display("FAIL ov_over_adel: got flags=%b, want 0000010010000", flags);
        end
    endtask

    task automatic test_cp0;
        logic k;
        issue(32'hBFC00400, 32'h40846000, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b000000_0000_100 || mem_addr_cp0 !== 5'd12) begin
            bad++;
            $display("FAIL mtc0: got flags=%b addr=%0d, want 0000000000100/12", flags, mem_addr_cp0);
        end
        issue(32'hBFC00404, 32'h40846000, 1'b0, 1'b0, 1'b1, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b000001_0010_000) begin
            bad++;
            $display("FAIL mtc0_ov: got flags=%b, want 0000010010000", flags);
        end
        issue(32'hBFC00408, 32'h42000018, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        total++;
        if (flags !== 13'b000000_0000_001) begin
            bad++;
            $display("FAIL eret: got flags=%b, want 0000000000001", flags);
        end
    endtask

    task automatic test_stall_flush;
        logic k;
        issue(32'hBFC00502, 32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        mem_allowin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (mem_valid !== 1'b1 || flags !== 13'b100000_1000_000
                || mem_pc !== 32'hBFC00502 || mem_badaddr !== 32'hBFC00502) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got valid=%b flags=%b pc=%h badaddr=%h, want 1/1000001000000/bfc00502/bfc00502",
                         i, mem_valid, flags, mem_pc, mem_badaddr);
            end
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        total++;
        if (mem_valid !== 1'b0 || flags !== 13'b0 || id_allowin !== 1'b1) begin
            bad++;
            $display("FAIL flush: got valid=%b flags=%b allowin=%b, want 0/0/1", mem_valid, flags, id_allowin);
        end
        mem_allowin = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall;
        logic k;
        issue(32'hBFC00600, 32'h0000000C, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, k);
        mem_allowin = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b0;
        flush  = 1'b1;
        @(posedge clk); #1;
        total++;
        if (mem_valid !== 1'b0 || flags !== 13'b0 || mem_pc !== 32'hBFC00000 || mem_badaddr !== 32'h0) begin
            bad++;
            $display("FAIL reset_stall: got valid=%b flags=%b pc=%h badaddr=%h, want 0/0/bfc00000/0",
                     mem_valid, flags, mem_pc, mem_badaddr);
        end
        resetn      = 1'b1;
        flush       = 1'b0;
        mem_allowin = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        resetn           = 1'b0;
        flush            = 1'b0;
        if_valid         = 1'b0;
        if_pc            = 32'h0;
        id_inst          = 32'h0;
        id_is_branch     = 1'b0;
        id_inst_reserved = 1'b0;
        id_ready_go      = 1'b1;
        ex_ready_go      = 1'b1;
        ex_overflow      = 1'b0;
        ex_mem_addr      = 32'h0;
        ex_ld_w          = 1'b0;
        ex_ld_h          = 1'b0;
        ex_st_w          = 1'b0;
        ex_st_h          = 1'b0;
        mem_allowin      = 1'b1;

        test_reset();
        test_fetch();
        test_syscall();
        test_bd();
        test_data();
        test_cp0();
        test_stall_flush();
        test_reset_mid_stall();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
